// File: rtl/axi_line_streamer_if.sv
// AXI4 read-address and read-data channels between a read master and memory.
// master: the streamer; slave: DDR port or axi_emu model.
interface axi_line_streamer_if;
  logic [15:0]  arid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic         arvalid_m;
  logic         arready_m;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m;
  logic         rvalid_m;
  logic         rready_m;

  modport master (
    output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
    input  arready_m,
    input  rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
    output rready_m
  );

  modport slave (
    input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
    output arready_m,
    output rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
    input  rready_m
  );
endinterface

// File: rtl/axi_line_streamer.sv
// Fetches num_lines 512-bit lines from base_addr as AXI bursts and streams them out in order.
// Optional macro RRESP_CHECK_EN: flag bad RRESP as sticky err and stop issuing further bursts.
module axi_line_streamer #(
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  base_addr,
  input  logic [31:0]  num_lines,
  output logic         busy,
  output logic         done,
  output logic [511:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic [1:0]   dbg_state,
  axi_line_streamer_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a transfer occurs on any rising clk edge where valid and ready are
  // both high; valid never waits on ready, and a raised arvalid_m holds its payload.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [57:0]     addr_q, addr_d;
  logic [31:0]     remaining_q, remaining_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic [511:0]    fifo_mem [FIFO_DEPTH];

  logic [6:0]      page_left;
  logic [6:0]      len_cap;
  logic [6:0]      burst_len;
  logic [CW-1:0]   credits;
  logic            ar_ok;
  logic            ar_hs;
  logic            rready;
  logic            beat;
  logic            pop;
  logic            drain_done;
  logic            unused_bits;

  // Burst sizing: never cross a 4 KB page, never exceed the free FIFO reservation.
  always_comb begin
    page_left  = 7'd64 - {1'b0, addr_q[5:0]};
    len_cap    = (7'(MAX_BURST) < page_left) ? 7'(MAX_BURST) : page_left;
    burst_len  = (remaining_q < {25'd0, len_cap}) ? remaining_q[6:0] : len_cap;
    credits    = CW'(FIFO_DEPTH) - count_q - outstanding_q;
    ar_ok      = (remaining_q != 32'd0) && ({{(32-CW){1'b0}}, credits} >= {25'd0, burst_len});
    ar_hs      = bus.arvalid_m && bus.arready_m;
    beat       = bus.rvalid_m && rready && (bus.rid_m == 16'(AXI_ID));
    pop        = out_valid && out_ready;
    drain_done = (state_q == S_DRAIN) && (outstanding_q == '0) && (count_q == '0);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_q         <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
      abort_q       <= abort_d;
    end
  end

  // Data storage is not reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (beat) fifo_mem[wr_ptr_q] <= bus.rdata_m;
  end

  // Datapath next-state
  always_comb begin
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    err_d         = err_q;
    abort_d       = abort_q;

    if (state_q == S_IDLE && start) begin
      addr_d      = base_addr[63:6];
      remaining_d = num_lines;
      abort_d     = 1'b0;
    end
    if (ar_hs) begin
      addr_d      = addr_q + 58'(burst_len);
      remaining_d = remaining_q - 32'(burst_len);
    end
    // burst_len fits CW bits here: a handshake implies burst_len <= credits <= FIFO_DEPTH.
    outstanding_d = outstanding_q + (ar_hs ? CW'(burst_len) : CW'(0)) - (beat ? CW'(1) : CW'(0));
    count_d       = count_q + (beat ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    if (beat) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

`ifdef RRESP_CHECK_EN
    if (beat && bus.rresp_m != 2'b00) begin
      err_d   = 1'b1;
      abort_d = 1'b1;
    end
    // A presented AR is allowed to complete before issue is cut off.
    if (abort_d && !(bus.arvalid_m && !bus.arready_m)) remaining_d = '0;
`endif
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_lines == 32'd0) ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (remaining_d == 32'd0) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    rready        = 1'b0;
    bus.arvalid_m = 1'b0;
    case (state_q)
      S_ISSUE: begin
        busy          = 1'b1;
        rready        = 1'b1;
        bus.arvalid_m = ar_ok;
      end
      S_DRAIN: begin
        done   = drain_done;
        busy   = !drain_done;
        rready = !drain_done;
      end
      default: ;
    endcase
  end

  assign bus.rready_m = rready;
  assign bus.arid_m   = 16'(AXI_ID);
  assign bus.araddr_m = {addr_q, 6'b000000};
  assign bus.arlen_m  = {1'b0, burst_len - 7'd1};
  assign bus.arsize_m = 3'd6;
  assign out_valid    = (count_q != '0);
  assign out_data     = fifo_mem[rd_ptr_q];
  assign dbg_state    = state_q;

`ifdef RRESP_CHECK_EN
  assign err         = err_q;
  assign unused_bits = ^{base_addr[5:0], bus.rlast_m};
`else
  assign err         = 1'b0;
  assign unused_bits = ^{base_addr[5:0], bus.rlast_m, bus.rresp_m, err_q, err_d};
`endif

endmodule

// File: tb/tb_axi_line_streamer.sv
// Bench for axi_line_streamer: randomized memory slave, line/AR reference model, scoreboard.
// Build with +define+RRESP_CHECK_EN to also exercise the bad-response path.
module tb_axi_line_streamer;

  localparam int          FIFO_DEPTH = 32;
  localparam int          MAX_BURST  = 16;
  localparam logic [63:0] MEM_LIMIT  = 64'h10_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [63:0]  base_addr = '0;
  logic [31:0]  num_lines = '0;
  logic         busy, done, out_valid, err;
  logic [511:0] out_data;
  logic         out_ready = 1'b0;
  logic [1:0]   dbg_state;

  axi_line_streamer_if bus();

  axi_line_streamer #(.AXI_ID(0), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .dbg_state(dbg_state), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [63:0] addr; logic last; } beat_t;

  logic [511:0] exp_q[$];
  ar_t          exp_ar_q[$];
  beat_t        r_pend[$];
  int pass_cnt = 0, total_cnt = 0;
  int done_cnt = 0, issued_beats = 0, popped_lines = 0;
  int rdy_mode = 0;
  bit err_job = 1'b0, r_hs = 1'b0, cur_junk = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] line_data(input logic [63:0] a);
    logic [511:0] d;
    for (int k = 0; k < 16; k++)
      d[32*k +: 32] = (a[37:6] * 32'h9E3779B1) ^ (32'(k) * 32'h01000193) ^ 32'hC0DE0000;
    return d;
  endfunction

  // Reference: lines are consecutive from the aligned base; bursts are the largest
  // chunks allowed by MAX_BURST, the remaining count and the 4 KB page boundary.
  task automatic model_job(input logic [63:0] b, input int n);
    logic [63:0] a;
    int rem, pg, len;
    a = {b[63:6], 6'd0};
    for (int i = 0; i < n; i++) exp_q.push_back(line_data(a + 64'(64 * i)));
    rem = n;
    while (rem > 0) begin
      pg  = 64 - int'(a[11:6]);
      len = MAX_BURST;
      if (rem < len) len = rem;
      if (pg < len)  len = pg;
      exp_ar_q.push_back('{addr: a, len: 8'(len - 1)});
      a   = a + 64'(64 * len);
      rem = rem - len;
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.arvalid_m && bus.arready_m) begin
        if (exp_ar_q.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
        else begin
          ar_t e;
          e = exp_ar_q.pop_front();
          chk("ar_addr", bus.araddr_m, e.addr);
          chk("ar_len", bus.arlen_m, e.len);
          chk("ar_size_id", {bus.arsize_m, bus.arid_m}, {3'd6, 16'd0});
        end
        issued_beats += int'(bus.arlen_m) + 1;
        chk("ar_credit", (issued_beats - popped_lines) <= FIFO_DEPTH, 1'b1);
        for (int i = 0; i <= int'(bus.arlen_m); i++)
          r_pend.push_back('{addr: bus.araddr_m + 64'(64 * i), last: (i == int'(bus.arlen_m))});
      end
      r_hs = bus.rvalid_m && bus.rready_m;
      if (out_valid && out_ready) begin
        popped_lines++;
        if (exp_q.size() == 0) chk("out_unexpected", 1'b1, 1'b0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 1'b0);
      end
    end
  end

  // ---------------- memory slave and consumer drivers ----------------
  always begin
    @(posedge clk); #1;
    if (rst) begin
      r_pend.delete();
      bus.rvalid_m = 1'b0;
      cur_junk = 1'b0;
      r_hs = 1'b0;
    end else begin
      if (r_hs) begin
        if (!cur_junk) r_pend.delete(0);
        bus.rvalid_m = 1'b0;
        r_hs = 1'b0;
      end
      if (!bus.rvalid_m) begin
        if ($urandom_range(0, 9) == 0) begin
          cur_junk = 1'b1;
          bus.rvalid_m = 1'b1;
          bus.rid_m = 16'h0005;
          bus.rdata_m = '1;
          bus.rresp_m = 2'b00;
          bus.rlast_m = 1'b0;
        end else if (r_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          cur_junk = 1'b0;
          bus.rvalid_m = 1'b1;
          bus.rid_m = 16'h0000;
          bus.rdata_m = line_data(r_pend[0].addr);
          bus.rresp_m = (r_pend[0].addr >= MEM_LIMIT) ? 2'b10 : 2'b00;
          bus.rlast_m = r_pend[0].last;
        end
      end
    end
    bus.arready_m = ($urandom_range(0, 3) != 0);
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [63:0] b, input int n);
    @(posedge clk); #1;
    done_cnt = 0; issued_beats = 0; popped_lines = 0;
    model_job(b, n);
    base_addr = b; num_lines = 32'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input string name);
    int c;
    c = 0;
    while (done_cnt == 0 && c < 20000) begin @(posedge clk); c++; end
    chk({name, "_done_seen"}, done_cnt != 0, 1'b1);
    repeat (4) @(posedge clk);
    chk({name, "_done_once"}, done_cnt == 1, 1'b1);
    chk({name, "_busy_after"}, busy, 1'b0);
    if (!err_job) begin
      chk({name, "_lines_left"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_ars_left"}, 32'(exp_ar_q.size()), 32'd0);
    end
  endtask

  task automatic run_job(input string name, input logic [63:0] b, input int n, input int mode);
    rdy_mode = mode;
    start_job(b, n);
    finish_job(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.arready_m = 1'b0; bus.rvalid_m = 1'b0; bus.rid_m = '0;
    bus.rdata_m = '0; bus.rresp_m = '0; bus.rlast_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, out_valid, bus.arvalid_m, bus.rready_m, err}, 6'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single line at address 0; first AR one cycle after start
    rdy_mode = 0;
    start_job(64'h0, 1);
    @(negedge clk);
    chk("t1_arvalid_latency", {bus.arvalid_m, busy}, 2'b11);
    finish_job("t1");

    // page-crossing split: 4 lines to the page end, then 6
    run_job("t2", 64'hF00, 10, 1);

    // back-pressure: issue must stop at a full reservation
    rdy_mode = 2;
    start_job(64'h2000, 100);
    repeat (300) @(posedge clk);
    chk("t3_reserved", 32'(issued_beats), 32'(FIFO_DEPTH));
    chk("t3_stalled", {out_valid, busy}, 2'b11);
    rdy_mode = 1;
    finish_job("t3");

    // empty job: done the cycle after start, no AR
    rdy_mode = 0;
    start_job(64'h40, 0);
    @(negedge clk);
    chk("t4_done_latency", {done, bus.arvalid_m}, 2'b10);
    finish_job("t4");

    // start while busy is ignored
    rdy_mode = 1;
    start_job(64'h8000, 20);
    repeat (5) @(posedge clk);
    chk("t4_busy_mid", busy, 1'b1);
    #1 base_addr = 64'h0; num_lines = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_job("t4b");

`ifdef RRESP_CHECK_EN
    // bad response beyond memory: err, issue stops, job still completes
    err_job = 1'b1;
    run_job("t5", MEM_LIMIT - 64'd256, 40, 1);
    chk("t5_err", err, 1'b1);
    chk("t5_issue_stopped", issued_beats < 40, 1'b1);
    chk("t5_issue_started", issued_beats >= 5, 1'b1);
    exp_q.delete(); exp_ar_q.delete();
    err_job = 1'b0;
`else
    chk("err_tied_low", err, 1'b0);
`endif

    // randomized jobs
    for (int j = 0; j < 6; j++) begin
      logic [63:0] b;
      b = {38'd0, 14'($urandom_range(0, 'h3000)), 6'($urandom_range(0, 63)), 6'd0};
      b[5:0] = 6'($urandom_range(0, 63));
      run_job("rand", b, $urandom_range(1, 80), $urandom_range(0, 1));
    end

    // asynchronous reset in the middle of a job, then a clean job
    rdy_mode = 1;
    start_job(64'h4000, 60);
    repeat (25) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("t6_reset_async", {busy, done, out_valid, bus.arvalid_m, bus.rready_m, err}, 6'd0);
    exp_q.delete(); exp_ar_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_job("t6_after", 64'h4800, 20, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
